conf_int_acc_stage: RTL and testbench

Downstream consumer of the configurable-precision integer adder. Accepts one adder sum per beat over a valid/ready handshake and keeps only the top OP_BITWIDTH bits, zeroing the rest. Accumulates ACC_LEN beats, or fewer on flush, into an unsigned accumulator. Presents the total on a held valid/ready output port for the next pipeline stage.

---
 rtl/conf_int_acc_stage.sv | 108 ++++++++++
 tb/tb_conf_int_acc_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_acc_stage.sv
// Accumulates masked adder sums over ACC_LEN beats (or fewer on flush) and holds the total
// on a valid/ready output. Optional macro SATURATE_ACC_EN clamps the accumulator on carry-out.
module conf_int_acc_stage #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_BITWIDTH       = 20,
  parameter int ACC_LEN            = 4,
  parameter int CNT_W              = $clog2(ACC_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_sum,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [ACC_BITWIDTH-1:0]       out_acc,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_ovf,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int DROP_BITS = DATA_PATH_BITWIDTH - OP_BITWIDTH;
  localparam logic [DATA_PATH_BITWIDTH-1:0] KEEP_MASK = {DATA_PATH_BITWIDTH{1'b1}} << DROP_BITS;

  typedef enum logic {ACCUM, FULL} state_t;

  state_t                    state_reg, state_next;
  logic [ACC_BITWIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic                      ovf_reg, ovf_next;
  logic [ACC_BITWIDTH-1:0]   out_acc_reg;
  logic [CNT_W-1:0]          out_count_reg;
  logic                      out_ovf_reg;
  logic [ACC_BITWIDTH-1:0]   masked;
  logic [ACC_BITWIDTH:0]     sum;
  logic                      accept;
  logic                      load_out;

  assign masked = ACC_BITWIDTH'(in_sum & KEEP_MASK);
  // Extra MSB of the add is the carry-out that drives overflow.
  assign sum    = {1'b0, acc_reg} + {1'b0, masked};
  assign accept = in_valid && (state_reg == ACCUM);

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    load_out   = 1'b0;
    case (state_reg)
      ACCUM: begin
        if (accept) begin
`ifdef SATURATE_ACC_EN
          acc_next = sum[ACC_BITWIDTH] ? {ACC_BITWIDTH{1'b1}} : sum[ACC_BITWIDTH-1:0];
`else
          acc_next = sum[ACC_BITWIDTH-1:0];
`endif
          cnt_next = cnt_reg + 1'b1;
          ovf_next = ovf_reg | sum[ACC_BITWIDTH];
        end
        // A flush with nothing accumulated and no beat this cycle is dropped.
        if ((accept && (cnt_next == CNT_W'(ACC_LEN) || flush)) || (flush && cnt_reg != '0)) begin
          state_next = FULL;
          load_out   = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_acc_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      if (load_out) begin
        out_acc_reg   <= acc_next;
        out_count_reg <= cnt_next;
        out_ovf_reg   <= ovf_next;
      end
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == FULL);
  assign out_acc   = out_acc_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_conf_int_acc_stage.sv
// Scoreboard bench: a default-parameter instance plus a narrow one (OP=12, ACC=16, LEN=2)
// for masking and overflow.
module tb_conf_int_acc_stage;

  typedef struct packed {
    logic [19:0] acc;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  exp_t        q_main[$];
  exp_t        q_aux[$];

  // main instance (defaults)
  logic [15:0] in_sum;
  logic        in_valid, in_ready, flush, out_ovf, out_valid, out_ready;
  logic [19:0] out_acc;
  logic [2:0]  out_count;

  // narrow instance
  logic [15:0] a_in_sum;
  logic        a_in_valid, a_in_ready, a_flush, a_out_ovf, a_out_valid, a_out_ready;
  logic [15:0] a_out_acc;
  logic [1:0]  a_out_count;

  always #5 clk = ~clk;

  conf_int_acc_stage dut (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  conf_int_acc_stage #(
    .OP_BITWIDTH(12), .DATA_PATH_BITWIDTH(16), .ACC_BITWIDTH(16), .ACC_LEN(2)
  ) dut_aux (
    .clk(clk), .rst(rst), .in_sum(a_in_sum), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flush(a_flush), .out_acc(a_out_acc), .out_count(a_out_count), .out_ovf(a_out_ovf),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] v, input logic f);
    in_valid = 1'b1;
    in_sum   = v;
    flush    = f;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic abeat(input logic [15:0] v);
    a_in_valid = 1'b1;
    a_in_sum   = v;
    cyc();
    a_in_valid = 1'b0;
  endtask

  task automatic push_main(input logic [19:0] a, input logic [2:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    q_main.push_back(e);
  endtask

  task automatic push_aux(input logic [19:0] a, input logic [2:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    q_aux.push_back(e);
  endtask

  // Monitors: compare at every completed output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected: out_acc=%0h out_count=%0d with no result expected", out_acc, out_count);
      end else begin
        e = q_main.pop_front();
        if (out_acc !== e.acc || out_count !== e.cnt || out_ovf !== e.ovf) begin
          errors++;
          $display("FAIL main_result: got acc=%0h cnt=%0d ovf=%0b, expected acc=%0h cnt=%0d ovf=%0b",
                   out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
        end else
          $display("main result acc=%0h cnt=%0d ovf=%0b ok", out_acc, out_count, out_ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && a_out_valid && a_out_ready) begin
      checks++;
      if (q_aux.size() == 0) begin
        errors++;
        $display("FAIL aux_unexpected: out_acc=%0h with no result expected", a_out_acc);
      end else begin
        e = q_aux.pop_front();
        if ({4'b0, a_out_acc} !== e.acc || {1'b0, a_out_count} !== e.cnt || a_out_ovf !== e.ovf) begin
          errors++;
          $display("FAIL aux_result: got acc=%0h cnt=%0d ovf=%0b, expected acc=%0h cnt=%0d ovf=%0b",
                   a_out_acc, a_out_count, a_out_ovf, e.acc, e.cnt, e.ovf);
        end else
          $display("aux result acc=%0h cnt=%0d ovf=%0b ok", a_out_acc, a_out_count, a_out_ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    in_sum = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a_in_sum = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    #2;
    chk("reset_out_acc", 32'(out_acc), 0);
    chk("reset_out_count", 32'(out_count), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    repeat (2) cyc();
    rst = 1'b1;

    // basic
    push_main(20'd10, 3'd4, 1'b0);
    beat(16'd1, 1'b0); beat(16'd2, 1'b0); beat(16'd3, 1'b0); beat(16'd4, 1'b0);
    chk("basic_in_ready_low", 32'(in_ready), 0);
    chk("basic_out_valid_high", 32'(out_valid), 1);
    cyc();
    chk("basic_in_ready_back", 32'(in_ready), 1);
    chk("basic_out_valid_low", 32'(out_valid), 0);

    // backpressure; beats and flush offered while full must be ignored
    out_ready = 1'b0;
    push_main(20'd4, 3'd4, 1'b0);
    repeat (4) beat(16'd1, 1'b0);
    in_valid = 1'b1; in_sum = 16'd7; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_acc", 32'(out_acc), 4);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_release_in_ready", 32'(in_ready), 1);

    // flush
    push_main(20'd12, 3'd2, 1'b0);
    beat(16'd5, 1'b0); beat(16'd7, 1'b0);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 1);
    cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_empty_no_valid", 32'(out_valid), 0);
    cyc();
    chk("flush_empty_no_valid2", 32'(out_valid), 0);
    push_main(20'd21, 3'd3, 1'b0);
    beat(16'd5, 1'b0); beat(16'd7, 1'b0); beat(16'd9, 1'b1);
    cyc();

    // reset mid-accumulation
    repeat (3) beat(16'd100, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_out_acc", 32'(out_acc), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_out_ovf", 32'(out_ovf), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    cyc();
    rst = 1'b1;
    push_main(20'd4, 3'd4, 1'b0);
    repeat (4) beat(16'd1, 1'b0);
    cyc();

    // large values: 4 * 0xFFFF fits in 20 bits
    push_main(20'h3FFFC, 3'd4, 1'b0);
    repeat (4) beat(16'hFFFF, 1'b0);
    cyc();

    // narrow instance: masking to top 12 bits, overflow at 16 bits
    push_aux(20'h001E0, 3'd2, 1'b0);
    abeat(16'h00FF); abeat(16'h00FF);
    cyc();
`ifdef SATURATE_ACC_EN
    push_aux(20'h0FFFF, 3'd2, 1'b1);
`else
    push_aux(20'h0FFE0, 3'd2, 1'b1);
`endif
    abeat(16'hFFFF); abeat(16'hFFFF);
    cyc();
`ifdef SATURATE_ACC_EN
    push_aux(20'h0FFFF, 3'd2, 1'b1);
`else
    push_aux(20'h00000, 3'd2, 1'b1);
`endif
    abeat(16'hFFFF); abeat(16'h0010);
    cyc();
    push_aux(20'h00010, 3'd2, 1'b0);
    abeat(16'h0001); abeat(16'h0010);
    cyc();

    repeat (3) cyc();
    chk("main_queue_drained", 32'(q_main.size()), 0);
    chk("aux_queue_drained", 32'(q_aux.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
